// File: rtl/collision_ci_master.sv
`default_nettype none
// ============================================================================
// Module   : collision_ci_master
// Function : Initiator for the collision-search CI unit; loads the message,
//            searches, polls and reads the counter for each target in a range.
//            Optional macro COLLISION_DIGEST_POLL_EN adds an n=4 read per poll.
// Revision : 1.0 - initial release
// ============================================================================
module collision_ci_master #(
  parameter int WORD_SIZE   = 32,
  parameter int TOTAL_WORDS = 16,
  parameter int TARGET_W    = 8,
  parameter int POLL_GAP    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             go,
  input  logic [WORD_SIZE*TOTAL_WORDS-1:0] msg_in,
  input  logic [TARGET_W-1:0]              first_target,
  input  logic [TARGET_W-1:0]              num_targets,
  output logic                             ci_clk_en,
  output logic                             ci_reset,
  output logic                             ci_start,
  output logic [WORD_SIZE-1:0]             ci_dataa,
  output logic [WORD_SIZE-1:0]             ci_datab,
  output logic [2:0]                       ci_n,
  input  logic                             ci_done,
  input  logic [WORD_SIZE-1:0]             ci_result,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [TARGET_W-1:0]              res_target,
  output logic [WORD_SIZE-1:0]             res_counter,
  output logic                             busy,
  output logic                             run_done
`ifdef COLLISION_DIGEST_POLL_EN
  ,
  output logic [WORD_SIZE-1:0]             digests
`endif
);

  localparam int c_MSG_W = WORD_SIZE * TOTAL_WORDS;
  localparam int c_KW    = $clog2(TOTAL_WORDS);
  localparam int c_GW    = $clog2(POLL_GAP + 2);
  localparam logic [c_KW-1:0] c_LAST_K   = c_KW'(TOTAL_WORDS - 2);
  localparam logic [c_GW-1:0] c_GAP_INIT = c_GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, LOAD_ISSUE, LOAD_WAIT, SEARCH_ISSUE, SEARCH_WAIT, GAP,
    DIG_ISSUE, DIG_WAIT, STAT_ISSUE, STAT_WAIT, READ_ISSUE, READ_WAIT,
    REPORT, FIN
  } state_t;

`ifdef COLLISION_DIGEST_POLL_EN
  localparam state_t     c_POLL_STATE = DIG_ISSUE;
  localparam logic [2:0] c_POLL_N     = 3'd4;
`else
  localparam state_t     c_POLL_STATE = STAT_ISSUE;
  localparam logic [2:0] c_POLL_N     = 3'd3;
`endif

  state_t                 r_state;
  logic                   r_ci_reset;
  logic                   r_start;
  logic [WORD_SIZE-1:0]   r_a;
  logic [WORD_SIZE-1:0]   r_b;
  logic [2:0]             r_n;
  logic                   r_valid;
  logic [TARGET_W-1:0]    r_res_tgt;
  logic [WORD_SIZE-1:0]   r_res_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic [c_MSG_W-1:0]     r_msg;
  logic [TARGET_W-1:0]    r_tgt;
  logic [TARGET_W-1:0]    r_rem;
  logic [c_KW-1:0]        r_k;
  logic [c_GW-1:0]        r_gap;
`ifdef COLLISION_DIGEST_POLL_EN
  logic [WORD_SIZE-1:0]   r_digests;
  assign digests = r_digests;
`endif

  // Word 0 sits in the most significant slice of the packed message.
  function automatic logic [WORD_SIZE-1:0] f_word(input logic [c_MSG_W-1:0] msg, input int idx);
    return msg[(TOTAL_WORDS-1-idx)*WORD_SIZE +: WORD_SIZE];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ci_reset <= 1'b1;
      r_start    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_n        <= '0;
      r_valid    <= 1'b0;
      r_res_tgt  <= '0;
      r_res_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_msg      <= '0;
      r_tgt      <= '0;
      r_rem      <= '0;
      r_k        <= '0;
      r_gap      <= '0;
`ifdef COLLISION_DIGEST_POLL_EN
      r_digests  <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: if (go) begin
          r_msg <= msg_in;
          r_tgt <= first_target;
          r_rem <= num_targets;
          if (num_targets == '0) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end else begin
            r_busy  <= 1'b1;
            r_state <= LOAD_ISSUE; r_start <= 1'b1; r_ci_reset <= 1'b0;
            r_n <= 3'd0; r_a <= f_word(msg_in, 0); r_b <= f_word(msg_in, 1);
            r_k <= '0;
          end
        end
        LOAD_ISSUE: r_state <= LOAD_WAIT;
        LOAD_WAIT: if (ci_done) begin
          if (r_k == c_LAST_K) begin
            r_state <= SEARCH_ISSUE; r_start <= 1'b1; r_ci_reset <= 1'b0;
            r_n <= 3'd1; r_a <= WORD_SIZE'(r_tgt); r_b <= '0;
          end else begin
            r_state <= LOAD_ISSUE; r_start <= 1'b1; r_ci_reset <= 1'b0;
            r_n <= 3'd0; r_a <= f_word(r_msg, int'(r_k) + 2); r_b <= f_word(r_msg, int'(r_k) + 3);
            r_k <= r_k + c_KW'(2);
          end
        end
        SEARCH_ISSUE: r_state <= SEARCH_WAIT;
        SEARCH_WAIT: if (ci_done) begin
          if (POLL_GAP == 0) begin
            r_state <= c_POLL_STATE; r_start <= 1'b1; r_ci_reset <= 1'b0;
            r_n <= c_POLL_N; r_a <= '0; r_b <= '0;
          end else begin
            r_state <= GAP;
            r_gap   <= c_GAP_INIT;
          end
        end
        GAP: begin
          if (r_gap == '0) begin
            r_state <= c_POLL_STATE; r_start <= 1'b1; r_ci_reset <= 1'b0;
            r_n <= c_POLL_N; r_a <= '0; r_b <= '0;
          end else begin
            r_gap <= r_gap - c_GW'(1);
          end
        end
        DIG_ISSUE: r_state <= DIG_WAIT;
        DIG_WAIT: if (ci_done) begin
`ifdef COLLISION_DIGEST_POLL_EN
          r_digests <= ci_result;
`endif
          r_state <= STAT_ISSUE; r_start <= 1'b1; r_ci_reset <= 1'b0;
          r_n <= 3'd3; r_a <= '0; r_b <= '0;
        end
        STAT_ISSUE: r_state <= STAT_WAIT;
        STAT_WAIT: if (ci_done) begin
          if (ci_result == WORD_SIZE'(1)) begin
            r_state <= READ_ISSUE; r_start <= 1'b1; r_ci_reset <= 1'b0;
            r_n <= 3'd2; r_a <= '0; r_b <= '0;
          end else if (POLL_GAP == 0) begin
            r_state <= c_POLL_STATE; r_start <= 1'b1; r_ci_reset <= 1'b0;
            r_n <= c_POLL_N; r_a <= '0; r_b <= '0;
          end else begin
            r_state <= GAP;
            r_gap   <= c_GAP_INIT;
          end
        end
        READ_ISSUE: r_state <= READ_WAIT;
        READ_WAIT: if (ci_done) begin
          r_res_cnt <= ci_result;
          r_res_tgt <= r_tgt;
          r_valid   <= 1'b1;
          r_state   <= REPORT;
        end
        // Message is reloaded for every target since the CI unit may clobber it.
        REPORT: if (res_ready) begin
          r_valid <= 1'b0;
          r_tgt   <= r_tgt + TARGET_W'(1);
          r_rem   <= r_rem - TARGET_W'(1);
          if (r_rem == TARGET_W'(1)) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= LOAD_ISSUE; r_start <= 1'b1; r_ci_reset <= 1'b0;
            r_n <= 3'd0; r_a <= f_word(r_msg, 0); r_b <= f_word(r_msg, 1);
            r_k <= '0;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ci_clk_en   = 1'b1;
  assign ci_reset    = r_ci_reset;
  assign ci_start    = r_start;
  assign ci_dataa    = r_a;
  assign ci_datab    = r_b;
  assign ci_n        = r_n;
  assign res_valid   = r_valid;
  assign res_target  = r_res_tgt;
  assign res_counter = r_res_cnt;
  assign busy        = r_busy;
  assign run_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_collision_ci_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_collision_ci_master
// Function : Scoreboard bench with a CI-unit responder and result monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_collision_ci_master;
  localparam int WS  = 32;
  localparam int NW  = 16;
  localparam int TGW = 8;
  localparam int GAP = 4;

  typedef struct packed { logic [2:0] n; logic [31:0] a; logic [31:0] b; } iss_t;
  typedef struct packed { logic [7:0] t; logic [31:0] c; logic [31:0] d; } res_t;

  logic clk = 1'b0, reset = 1'b0, go = 1'b0;
  logic [WS*NW-1:0] msg_in = '0;
  logic [TGW-1:0] first_target = '0, num_targets = '0;
  logic ci_clk_en, ci_reset, ci_start, ci_done, res_valid, res_ready, busy, run_done;
  logic [WS-1:0] ci_dataa, ci_datab, ci_result, res_counter;
  logic [2:0] ci_n;
  logic [TGW-1:0] res_target;
`ifdef COLLISION_DIGEST_POLL_EN
  logic [WS-1:0] digests;
`endif

  collision_ci_master #(.WORD_SIZE(WS), .TOTAL_WORDS(NW), .TARGET_W(TGW), .POLL_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .go(go), .msg_in(msg_in),
    .first_target(first_target), .num_targets(num_targets),
    .ci_clk_en(ci_clk_en), .ci_reset(ci_reset), .ci_start(ci_start),
    .ci_dataa(ci_dataa), .ci_datab(ci_datab), .ci_n(ci_n),
    .ci_done(ci_done), .ci_result(ci_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_target(res_target),
    .res_counter(res_counter), .busy(busy), .run_done(run_done)
`ifdef COLLISION_DIGEST_POLL_EN
    , .digests(digests)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0, hs_cyc = 0, bp_hold = 0;
  iss_t exp_iss_q[$];
  res_t exp_res_q[$];
  logic [31:0] stat_q[$], cnt_q[$], dig_q[$];
  logic [WS*NW-1:0] cur_msg;

  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [WS*NW-1:0] rand_msg();
    logic [WS*NW-1:0] m;
    for (int i = 0; i < NW; i++) m[i*WS +: WS] = $urandom;
    return m;
  endfunction

  function automatic logic [31:0] word_of(input logic [WS*NW-1:0] m, input int k);
    return m[(NW-1-k)*WS +: WS];
  endfunction

  // Reference: the CI traffic a correct initiator produces for one target.
  task automatic add_target(input logic [7:0] t, input int polls, input logic [31:0] cnt,
                            input logic [31:0] dig0, input bit zero_stat);
    res_t r;
    for (int k = 0; k < NW; k += 2) exp_iss_q.push_back({3'd0, word_of(cur_msg, k), word_of(cur_msg, k+1)});
    exp_iss_q.push_back({3'd1, 24'd0, t, 32'd0});
    for (int p = 0; p < polls; p++) begin
`ifdef COLLISION_DIGEST_POLL_EN
      exp_iss_q.push_back({3'd4, 32'd0, 32'd0});
`endif
      exp_iss_q.push_back({3'd3, 32'd0, 32'd0});
      dig_q.push_back(dig0 + 32'(100 * p));
      if (p == polls - 1) stat_q.push_back(32'd1);
      else stat_q.push_back(zero_stat ? 32'd0 : ($urandom | 32'd2));
    end
    exp_iss_q.push_back({3'd2, 32'd0, 32'd0});
    cnt_q.push_back(cnt);
    r.t = t; r.c = cnt; r.d = dig0 + 32'(100 * (polls - 1));
    exp_res_q.push_back(r);
  endtask

  task automatic check_reset_vals();
    chk("rst_ctrl", {ci_clk_en, ci_reset, ci_start, ci_n}, 6'b110000);
    chk("rst_ops", {ci_dataa, ci_datab}, 64'd0);
    chk("rst_res", {res_valid, res_target, res_counter}, 41'd0);
    chk("rst_status", {busy, run_done}, 2'b00);
`ifdef COLLISION_DIGEST_POLL_EN
    chk("rst_digests", digests, 32'd0);
`endif
  endtask

  task automatic start_and_wait(input logic [7:0] first, input logic [7:0] num, input bit busy_go);
    bit seen = 0;
    @(negedge clk);
    msg_in = cur_msg; first_target = first; num_targets = num; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0; msg_in = rand_msg(); first_target = 8'($urandom); num_targets = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 0 && num != 0) chk("busy_in_run", busy, 1);
      if (run_done) begin
        seen = 1;
        if (num == 0) chk("zero_done_latency", c, 0);
        else chk("run_done_after_accept", cyc - hs_cyc, 1);
        chk("results_drained", exp_res_q.size(), 0);
        chk("issues_drained", exp_iss_q.size(), 0);
        chk("busy_at_done", busy, 0);
        break;
      end
      if (busy_go && c == 20) begin
        num_targets = 8'($urandom_range(1, 200)); go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
      end
    end
    if (!seen) chk("run_done_timeout", seen, 1);
    @(negedge clk);
    chk("run_done_pulse", run_done, 0);
  endtask

  task automatic rand_run(input bit busy_go);
    logic [7:0] f, num;
    f = 8'($urandom); num = 8'($urandom_range(1, 3));
    cur_msg = rand_msg();
    for (int i = 0; i < int'(num); i++)
      add_target(f + 8'(i), $urandom_range(1, 4), $urandom, $urandom, 1'b0);
    start_and_wait(f, num, busy_go);
  endtask

  // CI-unit responder: checks every issue against the expected stream.
  initial begin : ci_model
    iss_t cur, e;
    bit pending = 0, was_pending, issued = 0;
    int lat = 0, last_n = 7, last_cyc = 0;
    logic [31:0] resp = 0, last_res = 0;
    ci_done = 1'b0; ci_result = '0;
    forever begin
      @(posedge clk); #1;
      ci_done = 1'b0;
      if (!reset) begin pending = 0; issued = 0; last_n = 7; continue; end
      was_pending = pending;
      if (pending) begin
        chk("op_stable", {ci_n, ci_dataa, ci_datab}, cur);
        if (lat == 0) begin
          ci_done = 1'b1; ci_result = resp; pending = 0;
          last_n = int'(cur.n); last_res = resp; last_cyc = cyc;
        end else lat--;
      end
      if (ci_start) begin
        issued = 1;
        chk("issue_while_wait", was_pending, 0);
        chk("issue_during_report", res_valid, 0);
        if (exp_iss_q.size() == 0) chk("issue_expected", exp_iss_q.size(), 1);
        else begin
          e = exp_iss_q.pop_front();
          chk("issue", {ci_n, ci_dataa, ci_datab}, e);
        end
        if (last_n == 1 || (last_n == 3 && last_res != 32'd1)) chk("poll_gap", cyc - last_cyc, GAP + 1);
        last_n = 7;
        case (ci_n)
          3'd3:    resp = (stat_q.size() > 0) ? stat_q.pop_front() : 32'd1;
          3'd2:    resp = (cnt_q.size() > 0) ? cnt_q.pop_front() : 32'd0;
          3'd4:    resp = (dig_q.size() > 0) ? dig_q.pop_front() : 32'd0;
          default: resp = $urandom;
        endcase
        cur = {ci_n, ci_dataa, ci_datab};
        pending = 1; lat = $urandom_range(0, 2);
        if ($urandom_range(0, 3) == 0) begin ci_done = 1'b1; ci_result = $urandom | 32'd1; end
      end
      chk("ci_reset", ci_reset, !issued);
    end
  end

  initial begin : rdy_drv
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (bp_hold > 0 && res_valid) begin res_ready = 1'b0; bp_hold--; end
      else res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Result monitor: pops the scoreboard on each handshake.
  initial begin : res_mon
    res_t r;
    bit pv = 0;
    logic [7:0] pt = 0;
    logic [31:0] pc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin pv = 0; continue; end
      if (pv) chk("bp_hold", {res_valid, res_target, res_counter}, {1'b1, pt, pc});
      if (res_valid && res_ready) begin
        hs_cyc = cyc;
        if (exp_res_q.size() == 0) chk("result_expected", exp_res_q.size(), 1);
        else begin
          r = exp_res_q.pop_front();
          chk("res_target", res_target, r.t);
          chk("res_counter", res_counter, r.c);
`ifdef COLLISION_DIGEST_POLL_EN
          chk("digests", digests, r.d);
`endif
        end
      end
      pv = res_valid && !res_ready; pt = res_target; pc = res_counter;
    end
  end

  initial begin : stim
    bit found;
    logic [7:0] t;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b1;
    repeat (3) @(negedge clk);

    cur_msg = rand_msg();
    cur_msg[WS*NW-1 -: WS] = 32'h5858_5858;
    add_target(8'd5, 3, 32'h0000_ABCD, 32'd100, 1'b1);
    start_and_wait(8'd5, 8'd1, 1'b0);

    cur_msg = rand_msg();
    add_target(8'd9, 2, $urandom, 32'd100, 1'b1);
    start_and_wait(8'd9, 8'd1, 1'b0);

    bp_hold = 10;
    cur_msg = rand_msg();
    add_target(8'h33, 1, $urandom, $urandom, 1'b0);
    add_target(8'h34, 2, $urandom, $urandom, 1'b0);
    start_and_wait(8'h33, 8'd2, 1'b0);

    cur_msg = rand_msg();
    for (int i = 0; i < 3; i++) begin
      t = 8'hFE + 8'(i);
      add_target(t, $urandom_range(1, 3), $urandom, $urandom, 1'b0);
    end
    start_and_wait(8'hFE, 8'd3, 1'b0);

    start_and_wait(8'($urandom), 8'd0, 1'b0);
    rand_run(1'b1);
    repeat (4) rand_run(1'b0);

    cur_msg = rand_msg();
    add_target(8'h77, 4, $urandom, $urandom, 1'b0);
    @(negedge clk);
    msg_in = cur_msg; first_target = 8'h77; num_targets = 8'd1; go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    found = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (ci_start && ci_n == 3'd3) begin found = 1; break; end
    end
    chk("reached_stat_wait", found, 1);
    @(negedge clk); #2 reset = 1'b0;
    #1 check_reset_vals();
    exp_iss_q.delete(); exp_res_q.delete(); stat_q.delete(); cnt_q.delete(); dig_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals();
    rand_run(1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
